latency_ram: RTL

//  Single-port, word-organised RAM with a programmable access latency. It sits directly

---
 rtl/latency_ram.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/latency_ram.sv
// Single-port byte-laned word RAM with programmable access latency; one request at a time.
// Optional RAM_BOUNDS_CHECK_EN adds ram_err and suppresses out-of-range accesses.
package rv32ima_pkg;
  typedef enum logic [1:0] {
    RAM_FREE = 2'b00,
    RAM_BUSY = 2'b01,
    RAM_DATA = 2'b10
  } ram_state_t;
endpackage

module latency_ram
  import rv32ima_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT_CYCLES  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ram_addr,
  input  logic        ram_ren,
  input  logic        ram_wen,
  input  logic [31:0] ram_store,
  input  logic [1:0]  ram_width,
  output logic [31:0] ram_load,
  output ram_state_t  ram_state
`ifdef RAM_BOUNDS_CHECK_EN
  ,
  output logic        ram_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  ram_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      store_q, store_d;
  logic [1:0]       width_q, width_d;
  logic             wr_q, wr_d;
  logic [31:0]      load_q, load_d;
  logic             err_q, err_d;

  logic             finish;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_store;
  logic [1:0]       acc_width;
  logic             acc_wr;
  logic [IDX_W-1:0] idx;
  logic             oob;
  logic [31:0]      word_rd;
  logic [31:0]      rd_lane;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             mem_we;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    store_d   = store_q;
    width_d   = width_q;
    wr_d      = wr_q;
    load_d    = load_q;
    err_d     = 1'b0;
    finish    = 1'b0;
    acc_addr  = addr_q;
    acc_store = store_q;
    acc_width = width_q;
    acc_wr    = wr_q;

    case (state_q)
      RAM_FREE: begin
        if (ram_ren || ram_wen) begin
          addr_d    = ram_addr;
          store_d   = ram_store;
          width_d   = ram_width;
          wr_d      = ram_wen;
          acc_addr  = ram_addr;
          acc_store = ram_store;
          acc_width = ram_width;
          acc_wr    = ram_wen;
          cnt_d     = CNT_W'(LAT_CYCLES - 1);
          if (LAT_CYCLES == 1) begin
            finish = 1'b1;
          end else begin
            state_d = RAM_BUSY;
          end
        end
      end
      RAM_BUSY: begin
        // Requester withdrawing both strobes cancels the access outright.
        if (!ram_ren && !ram_wen) begin
          state_d = RAM_FREE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            finish = 1'b1;
          end
        end
      end
      default: state_d = RAM_FREE;
    endcase

    idx = acc_addr[IDX_W+1:2];
`ifdef RAM_BOUNDS_CHECK_EN
    oob = ({1'b0, acc_addr} >= 33'(4 * DEPTH_WORDS));
`else
    oob = 1'b0;
`endif

    word_rd = mem[idx];
    case (acc_width)
      2'b00: begin
        rd_lane = {24'b0, word_rd[8*acc_addr[1:0] +: 8]};
        wdata   = {4{acc_store[7:0]}};
        be      = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        rd_lane = acc_addr[1] ? {16'b0, word_rd[31:16]} : {16'b0, word_rd[15:0]};
        wdata   = {2{acc_store[15:0]}};
        be      = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        rd_lane = word_rd;
        wdata   = acc_store;
        be      = 4'b1111;
      end
    endcase

    if (finish) begin
      state_d = RAM_DATA;
      err_d   = oob;
      load_d  = (acc_wr || oob) ? 32'b0 : rd_lane;
    end

    mem_we = finish && acc_wr && !oob && !RST;
  end

`ifndef RAM_BOUNDS_CHECK_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:IDX_W+2];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RAM_FREE;
      cnt_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
      width_q <= '0;
      wr_q    <= 1'b0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      width_q <= width_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign ram_load  = load_q;
  assign ram_state = state_q;
`ifdef RAM_BOUNDS_CHECK_EN
  assign ram_err   = err_q;
`endif

endmodule
